// File: rtl/calc1_req_driver.sv
// Request-side driver for one calc1 port: serialises an op over two cycles, waits for the response or a timeout.
// Optional result checking is enabled by defining CALC1_DRV_CHECK_EN, which adds the mismatch output.
module calc1_req_driver #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_cmd,
  input  logic [31:0]      op_data1,
  input  logic [31:0]      op_data2,
  output logic [3:0]       req_cmd_out,
  output logic [31:0]      req_data_out,
  input  logic [1:0]       out_resp_in,
  input  logic [31:0]      out_data_in,
  output logic             res_valid,
  output logic [3:0]       res_cmd,
  output logic [1:0]       res_resp,
  output logic [31:0]      res_data,
  output logic             res_timeout,
  output logic             spurious_resp,
  output logic [CNT_W-1:0] ops_sent,
  output logic [CNT_W-1:0] timeouts
`ifdef CALC1_DRV_CHECK_EN
  ,
  output logic             mismatch
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SEND1, S_SEND2, S_WAIT} state_t;

  localparam logic [9:0]       TIMEOUT_L = 10'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t      state_reg;
  logic [3:0]  cmd_reg;
  logic [31:0] data1_reg;
  logic [31:0] data2_reg;
  logic [9:0]  wait_cnt_reg;
  logic [9:0]  wait_cnt_next;
  logic        resp_seen;

  assign op_ready      = (state_reg == S_IDLE);
  assign wait_cnt_next = wait_cnt_reg + 10'd1;
  assign resp_seen     = (out_resp_in != 2'd0);

`ifdef CALC1_DRV_CHECK_EN
  logic [32:0] sum_full;
  logic [1:0]  exp_resp;
  logic [31:0] exp_data;
  logic        check_bad;

  always_comb begin
    sum_full = {1'b0, data1_reg} + {1'b0, data2_reg};
    exp_resp = 2'd1;
    exp_data = '0;
    case (cmd_reg)
      4'd1: begin
        exp_data = sum_full[31:0];
        if (sum_full[32]) exp_resp = 2'd2;
      end
      4'd2: begin
        exp_data = data1_reg - data2_reg;
        if (data2_reg > data1_reg) exp_resp = 2'd2;
      end
      4'd5:    exp_data = data1_reg << data2_reg[4:0];
      4'd6:    exp_data = data1_reg >> data2_reg[4:0];
      default: exp_resp = 2'd2;
    endcase
    // Data only matters when a successful result is expected.
    check_bad = (out_resp_in != exp_resp) ||
                ((exp_resp == 2'd1) && (out_data_in != exp_data));
  end
`endif

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cmd_reg       <= '0;
      data1_reg     <= '0;
      data2_reg     <= '0;
      wait_cnt_reg  <= '0;
      req_cmd_out   <= '0;
      req_data_out  <= '0;
      res_valid     <= 1'b0;
      res_cmd       <= '0;
      res_resp      <= '0;
      res_data      <= '0;
      res_timeout   <= 1'b0;
      spurious_resp <= 1'b0;
      ops_sent      <= '0;
      timeouts      <= '0;
`ifdef CALC1_DRV_CHECK_EN
      mismatch      <= 1'b0;
`endif
    end else begin
      res_valid <= 1'b0;
`ifdef CALC1_DRV_CHECK_EN
      mismatch  <= 1'b0;
`endif
      if ((state_reg != S_WAIT) && resp_seen) spurious_resp <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          // A NOP is consumed here without touching the port.
          if (op_valid && (op_cmd != 4'd0)) begin
            cmd_reg      <= op_cmd;
            data1_reg    <= op_data1;
            data2_reg    <= op_data2;
            req_cmd_out  <= op_cmd;
            req_data_out <= op_data1;
            state_reg    <= S_SEND1;
          end
        end
        S_SEND1: begin
          req_cmd_out  <= '0;
          req_data_out <= data2_reg;
          if (ops_sent != CNT_MAX) ops_sent <= ops_sent + CNT_W'(1);
          state_reg    <= S_SEND2;
        end
        S_SEND2: begin
          req_data_out <= '0;
          wait_cnt_reg <= '0;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          // A response on the expiry edge takes priority over the timeout.
          if (resp_seen) begin
            res_valid   <= 1'b1;
            res_cmd     <= cmd_reg;
            res_resp    <= out_resp_in;
            res_data    <= out_data_in;
            res_timeout <= 1'b0;
            state_reg   <= S_IDLE;
`ifdef CALC1_DRV_CHECK_EN
            mismatch    <= check_bad;
`endif
          end else if (wait_cnt_next == TIMEOUT_L) begin
            res_valid   <= 1'b1;
            res_cmd     <= cmd_reg;
            res_resp    <= '0;
            res_data    <= '0;
            res_timeout <= 1'b1;
            if (timeouts != CNT_MAX) timeouts <= timeouts + CNT_W'(1);
            state_reg   <= S_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_next;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/calc1_req_driver.md
Name: calc1_req_driver

Overview:
- Initiator for one calc1 request port.
- Accepts one operation (command plus two operands) from a bench or sequencer and serialises it onto the port's cmd/data pins: the command with operand 1 in the first cycle, operand 2 in the second.
- Waits for the port's response, returns response and data to the sequencer, and enforces a response timeout.
- One instance per calc1 port; four instances drive a full calc1.

Parameters:
- TIMEOUT_CYCLES, 64: WAIT-state cycles allowed before an op is declared timed out (legal range 1..1023).
- CNT_W, 16: width of the statistics counters.

Ports:
- c_clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  sequencer presents an operation.
- op_ready  output  1  driver can accept an operation; high only in IDLE.
- op_cmd  input  4  command (0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH; any other value is passed through unchanged).
- op_data1  input  32  operand 1.
- op_data2  input  32  operand 2.
- req_cmd_out  output  4  command to the calc1 port.
- req_data_out  output  32  data to the calc1 port.
- out_resp_in  input  2  calc1 response (0 none, 1 success, 2 invalid/overflow, 3 internal error).
- out_data_in  input  32  calc1 result data.
- res_valid  output  1  one-cycle pulse: result fields valid.
- res_cmd  output  4  command that produced this result.
- res_resp  output  2  captured response.
- res_data  output  32  captured result data.
- res_timeout  output  1  result is a timeout, not a DUT response.
- spurious_resp  output  1  sticky: a nonzero response arrived outside WAIT.
- ops_sent  output  CNT_W  count of ops driven to the DUT (saturating).
- timeouts  output  CNT_W  count of timed-out ops (saturating).

Behaviour:
- Reset, applied on a posedge with reset=1:
  - State returns to IDLE.
  - Every output is 0 except op_ready=1.
  - Counters and spurious_resp are cleared.
  - An in-flight op is abandoned: no res_valid, cmd/data pins are 0 from that edge.
- State IDLE:
  - op_ready=1; req_cmd_out=0; req_data_out=0.
  - op_valid && op_cmd==0 at posedge: the op is consumed and dropped; no DUT traffic, no result; stay in IDLE.
  - op_valid && op_cmd!=0 at posedge k: latch cmd and both operands; go to SEND1.
- State SEND1, cycle k..k+1:
  - req_cmd_out=cmd; req_data_out=data1; op_ready=0.
  - At the next posedge go to SEND2 and increment ops_sent.
- State SEND2:
  - req_cmd_out=0; req_data_out=data2.
  - At the next posedge go to WAIT, clear the wait counter, set req_data_out=0.
- State WAIT:
  - Pins are 0. At each posedge sample out_resp_in.
  - If out_resp_in != 0: register res_resp, res_data=out_data_in, res_cmd, res_timeout=0; pulse res_valid for exactly 1 cycle; go to IDLE.
  - Else increment the wait counter. When the counter reaches TIMEOUT_CYCLES: pulse res_valid with res_timeout=1, res_resp=0, res_data=0; increment timeouts; go to IDLE.
  - Response on the same edge as timeout expiry: the response wins and no timeout is counted.
- Latency:
  - Earliest next op is accepted on the edge after res_valid, since op_ready is high again in IDLE.
  - Minimum op-to-op spacing is 4 cycles.
- Error flag: out_resp_in != 0 sampled in IDLE, SEND1 or SEND2 sets spurious_resp until reset.
- Counters saturate at all-ones.
- op_ready is combinational from state only, never from op_valid.
- Result fields hold their values after the pulse until the next result.

Optional Feature:
- Macro: CALC1_DRV_CHECK_EN.
- When defined: the driver computes the expected result from the latched op and adds output `mismatch` (1 bit), pulsed together with res_valid on a non-timeout result whose resp or data differs from expected.
- Expected results:
  - ADD: sum, resp 1; carry out gives resp 2, data don't-care.
  - SUB: difference, resp 1; data2 > data1 gives resp 2, data don't-care.
  - LSH/RSH: data1 shifted by data2[4:0] LSBs, resp 1.
  - Any other command: resp 2.
- When undefined: no `mismatch` port and no checking logic.

Test Plan:
- ADD 0x00000005, 0x00000003; DUT returns resp 1 data 8 three cycles into WAIT -> pins show cmd 1/data 5, then cmd 0/data 3, then 0; res_valid once with resp 1, data 8, cmd 1; ops_sent=1.
- No DUT response, TIMEOUT_CYCLES=4 -> res_valid with res_timeout=1 exactly 4 cycles after WAIT entry; timeouts=1; op_ready high next cycle.
- op_cmd=0 with op_valid -> pins stay 0, no res_valid, ops_sent unchanged.
- out_resp_in=1 forced during SEND1 -> spurious_resp=1 and held through later ops until reset.
- reset asserted in WAIT -> next edge: state IDLE, all outputs 0, op_ready=1; a DUT response arriving afterwards produces no res_valid.
- CHECK_EN: ADD 0xFFFFFFFF+1 with DUT resp 1 -> mismatch=1; SUB 2-5 with DUT resp 2 -> mismatch=0.
